// File: rtl/expr_alu_arbiter.sv
// Round-robin arbitrated ALU: grants one of NREQ requesters, executes its opcode
// (shifts iterate one bit per cycle) and holds the result until the consumer takes it.
module expr_alu_arbiter #(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [4*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy
);

    localparam int               CW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   cur_id;
    logic [3:0]       cur_op;
    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    logic             grant_any;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] sel_n;
    logic             is_shift;
    logic [WIDTH-1:0] shift1;
    logic [WIDTH-1:0] alu_res;

    function automatic logic [WIDTH-1:0] zext(input logic bit_in);
        return {{(WIDTH-1){1'b0}}, bit_in};
    endfunction

    // First valid requester at or above the priority pointer, wrapping around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // NOTE: req_ready is combinational so the handshake completes in the same cycle.
    assign req_ready = (state == IDLE && !rst && grant_any) ? (NREQ'(1) << grant_idx) : '0;

    assign sel_op = req_op[grant_idx*4 +: 4];
    assign sel_a  = req_a[grant_idx*WIDTH +: WIDTH];
    assign sel_b  = req_b[grant_idx*WIDTH +: WIDTH];
    assign sel_n  = sel_b % WIDTH_V;

    assign is_shift = (cur_op == 4'd10) || (cur_op == 4'd11) || (cur_op == 4'd12);

    always_comb begin
        case (cur_op)
            4'd10:   shift1 = {acc[WIDTH-2:0], 1'b0};
            4'd11:   shift1 = {1'b0, acc[WIDTH-1:1]};
            default: shift1 = {acc[WIDTH-1], acc[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        case (cur_op)
            4'd0:    alu_res = cur_a & cur_b;
            4'd1:    alu_res = cur_a | cur_b;
            4'd2:    alu_res = cur_a ^ cur_b;
            4'd3:    alu_res = ~(cur_a ^ cur_b);
            4'd4:    alu_res = zext((|cur_a) && (|cur_b));
            4'd5:    alu_res = zext((|cur_a) || (|cur_b));
            4'd6:    alu_res = zext(cur_a == cur_b);
            4'd7:    alu_res = zext(cur_a != cur_b);
            4'd8:    alu_res = zext(cur_a < cur_b);
            4'd9:    alu_res = zext(cur_a >= cur_b);
            4'd13:   alu_res = cur_a + cur_b;
            4'd14:   alu_res = cur_a - cur_b;
            4'd15:   alu_res = zext(^cur_a);
            default: alu_res = '0;
        endcase
    end

    // NOTE: only control and output registers are reset; operand registers are
    // always loaded on accept before they are read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cur_id <= grant_idx;
                        cur_op <= sel_op;
                        cur_a  <= sel_a;
                        cur_b  <= sel_b;
                        acc    <= sel_a;
                        cnt    <= CW'(sel_n);
                        ptr    <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                        state  <= EXEC;
                        busy   <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!is_shift || cnt == '0 || cnt == CW'(1)) begin
                        if (!is_shift)
                            rsp_data <= alu_res;
                        else if (cnt == '0)
                            rsp_data <= acc;
                        else
                            rsp_data <= shift1;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        acc <= shift1;
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expr_alu_arbiter.sv
// Randomized and directed bench for expr_alu_arbiter against a behavioural model
// of the round-robin grant rule, the opcode table and the execution latency.
module tb_expr_alu_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           busy;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;
    int ops[N];
    int as_[N];
    int bs[N];

    expr_alu_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ref_alu(input int op, input int a, input int b);
        int n;
        n = b % W;
        case (op)
            0:  return a & b;
            1:  return a | b;
            2:  return a ^ b;
            3:  return (~(a ^ b)) & 255;
            4:  return (a != 0 && b != 0) ? 1 : 0;
            5:  return (a != 0 || b != 0) ? 1 : 0;
            6:  return (a == b) ? 1 : 0;
            7:  return (a != b) ? 1 : 0;
            8:  return (a < b) ? 1 : 0;
            9:  return (a >= b) ? 1 : 0;
            10: return (a << n) & 255;
            11: return a >> n;
            12: return (a >= 128) ? ((a >> n) | (255 ^ (255 >> n))) : (a >> n);
            13: return (a + b) % 256;
            14: return (a - b + 256) % 256;
            default: return $countones(a) % 2;
        endcase
    endfunction

    function automatic int ref_lat(input int op, input int b);
        if (op >= 10 && op <= 12) return ((b % W) == 0) ? 1 : (b % W);
        return 1;
    endfunction

    function automatic int ref_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input int op, input int a, input int b);
        ops[i] = op; as_[i] = a; bs[i] = b;
        req_op[4*i +: 4] = 4'(op);
        req_a[W*i +: W]  = W'(a);
        req_b[W*i +: W]  = W'(b);
    endtask

    // Drives one handshake pair; returns at the RESP state if rsp_ready is low.
    task automatic run_txn(input bit drop, output logic [N-1:0] rdy, output int gid,
                           output int lat, output int data, output int id, output bit tmo);
        int k;
        tmo = 0; gid = -1; lat = 0; data = -1; id = -1; k = 0;
        #1;
        while (req_ready == '0 && k < 20) begin
            @(posedge clk); #1; k++;
        end
        rdy = req_ready;
        if (req_ready == '0) begin tmo = 1; return; end
        for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
        @(posedge clk); #1;
        if (drop) req_valid[gid] = 1'b0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) begin tmo = 1; return; end
        data = int'(rsp_data);
        id   = int'(rsp_id);
        if (rsp_ready) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        req_op = '0; req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready got=%b want=0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
        total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data got=%h want=00", rsp_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        req_valid = '0; rst = 1'b0; mptr = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int t_req[6] = '{0, 1, 2, 3, 0, 1};
        int t_op[6]  = '{13, 12, 10, 8, 14, 15};
        int t_a[6]   = '{8'hF0, 8'h90, 8'hA5, 8'h01, 8'h00, 8'h07};
        int t_b[6]   = '{8'h20, 8'h0B, 8'h08, 8'hFF, 8'h01, 8'h00};
        int t_exp[6] = '{8'h10, 8'hF2, 8'hA5, 8'h01, 8'hFF, 8'h01};
        int t_lat[6] = '{1, 3, 1, 1, 1, 1};
        logic [N-1:0] rdy;
        int gid, lat, data, id;
        bit tmo;
        for (int j = 0; j < 6; j++) begin
            req_valid = '0;
            set_req(t_req[j], t_op[j], t_a[j], t_b[j]);
            req_valid[t_req[j]] = 1'b1;
            run_txn(1'b1, rdy, gid, lat, data, id, tmo);
            total++;
            if (tmo) begin bad++; $display("FAIL dir%0d_timeout", j); continue; end
            if (gid !== t_req[j] || lat !== t_lat[j] || data !== t_exp[j] || id !== t_req[j]) begin
                bad++;
                $display("FAIL dir%0d got grant=%0d lat=%0d data=%h id=%0d want grant=%0d lat=%0d data=%h id=%0d",
                         j, gid, lat, data, id, t_req[j], t_lat[j], t_exp[j], t_req[j]);
            end
            mptr = (gid + 1) % N;
        end
    endtask

    task automatic test_round_robin();
        int cnt[N];
        logic [N-1:0] rdy;
        int gid, lat, data, id, exp_g;
        bit tmo;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            set_req(i, 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        req_valid = '1;
        for (int t = 0; t < 8; t++) begin
            exp_g = ref_grant(4'hF);
            run_txn(1'b0, rdy, gid, lat, data, id, tmo);
            total++;
            if (tmo) begin bad++; $display("FAIL rr%0d_timeout", t); break; end
            if (gid !== exp_g || data !== ref_alu(0, as_[exp_g], bs[exp_g])) begin
                bad++;
                $display("FAIL rr%0d got grant=%0d data=%h want grant=%0d data=%h",
                         t, gid, data, exp_g, ref_alu(0, as_[exp_g], bs[exp_g]));
            end
            cnt[gid]++;
            mptr = (gid + 1) % N;
        end
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            total++;
            if (cnt[i] !== 2) begin bad++; $display("FAIL rr_fair req%0d got=%0d want=2", i, cnt[i]); end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] mask, rdy;
        int gid, lat, data, id, exp_g, exp_d;
        bit tmo;
        for (int t = 0; t < 40; t++) begin
            mask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++)
                set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)));
            req_valid = mask;
            exp_g = ref_grant(mask);
            exp_d = ref_alu(ops[exp_g], as_[exp_g], bs[exp_g]);
            run_txn(1'b1, rdy, gid, lat, data, id, tmo);
            total++;
            if (tmo) begin bad++; $display("FAIL rnd%0d_timeout", t); break; end
            if (rdy !== (N'(1) << exp_g) || data !== exp_d || id !== exp_g ||
                lat !== ref_lat(ops[exp_g], bs[exp_g])) begin
                bad++;
                $display("FAIL rnd%0d op=%0d got ready=%b data=%h id=%0d lat=%0d want ready=%b data=%h id=%0d lat=%0d",
                         t, ops[exp_g], rdy, data, id, lat, N'(1) << exp_g, exp_d, exp_g,
                         ref_lat(ops[exp_g], bs[exp_g]));
            end
            mptr = (exp_g + 1) % N;
        end
        req_valid = '0;
    endtask

    task automatic test_hold();
        logic [N-1:0] rdy;
        int gid, lat, data, id, exp_g;
        bit tmo, held;
        req_valid = '0;
        set_req(2, 13, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        req_valid[2] = 1'b1;
        rsp_ready = 1'b0;
        run_txn(1'b1, rdy, gid, lat, data, id, tmo);
        total++;
        if (tmo || data !== ref_alu(13, as_[2], bs[2]) || id !== 2) begin
            bad++;
            $display("FAIL hold_resp got data=%h id=%0d tmo=%0d want data=%h id=2",
                     data, id, tmo, ref_alu(13, as_[2], bs[2]));
        end
        mptr = 3;
        held = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_valid = N'($urandom);
            req_op = 16'($urandom); req_a = 32'($urandom); req_b = 32'($urandom);
            #1;
            if (rsp_valid !== 1'b1 || int'(rsp_data) !== data || int'(rsp_id) !== id ||
                req_ready !== '0 || busy !== 1'b1) begin
                held = 1'b0;
                $display("FAIL hold_cycle%0d got valid=%b data=%h id=%0d ready=%b busy=%b want valid=1 data=%h id=%0d ready=0 busy=1",
                         c, rsp_valid, rsp_data, rsp_id, req_ready, busy, data, id);
            end
            @(posedge clk); #1;
        end
        total++; if (!held) bad++;
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== '0) begin bad++; $display("FAIL hold_release_ready got=%b want=0", req_ready); end
        @(posedge clk); #1;
        exp_g = ref_grant(4'hF);
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== (N'(1) << exp_g)) begin
            bad++;
            $display("FAIL hold_after got valid=%b busy=%b ready=%b want valid=0 busy=0 ready=%b",
                     rsp_valid, busy, req_ready, N'(1) << exp_g);
        end
        req_valid = '0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_drop_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_abort();
        logic [N-1:0] rdy;
        int gid, lat, data, id, k;
        bit tmo, quiet;
        req_valid = '0;
        set_req(3, 11, 8'hC3, 6);
        req_valid[3] = 1'b1;
        k = 0;
        #1;
        while (req_ready == '0 && k < 10) begin @(posedge clk); #1; k++; end
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL abort_grant got=%b want=1000", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_exec got busy=%b valid=%b want busy=1 valid=0", busy, rsp_valid); end
        rst = 1'b1;
        req_valid = '1;
        @(posedge clk); #1;
        total++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL abort_reset got ready=%b valid=%b busy=%b id=%0d data=%h want all zero",
                     req_ready, rsp_valid, busy, rsp_id, rsp_data);
        end
        rst = 1'b0;
        req_valid = '0;
        mptr = 0;
        quiet = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL abort_no_response got a response or busy after reset"); end
        for (int i = 0; i < N; i++) set_req(i, 6, i, i);
        req_valid = '1;
        run_txn(1'b1, rdy, gid, lat, data, id, tmo);
        total++;
        if (tmo || gid !== 0 || data !== 1 || id !== 0) begin
            bad++;
            $display("FAIL abort_next got grant=%0d data=%h id=%0d tmo=%0d want grant=0 data=01 id=0",
                     gid, data, id, tmo);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_round_robin();
        test_random();
        test_hold();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
